// File: rtl/inst_fifo.sv
// inst_fifo: show-ahead dual-push/dual-pop instruction queue feeding dual-issue decode.
module inst_fifo #(
  parameter int DEPTH = 16,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          write_en1,
  input  logic          write_en2,
  input  logic [DW-1:0] write_inst1,
  input  logic [DW-1:0] write_inst2,
  input  logic [DW-1:0] write_pc1,
  input  logic [DW-1:0] write_pc2,
  input  logic          read_en1,
  input  logic          read_en2,
  output logic [DW-1:0] read_inst1,
  output logic [DW-1:0] read_pc1,
  output logic [DW-1:0] read_inst2,
  output logic [DW-1:0] read_pc2,
  output logic          empty,
  output logic          almost_empty,
  output logic          full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] full_lvl = (AW+1)'(DEPTH - 1);
  logic [DW-1:0] inst_mem [DEPTH];
  logic [DW-1:0] pc_mem [DEPTH];
  logic [AW-1:0] head, tail, head1, tail1;
  logic [AW:0] count;
  logic [1:0] pops, pushes;
  assign head1 = head + AW'(1);
  assign tail1 = tail + AW'(1);
  assign empty = count == '0;
  assign almost_empty = count == (AW+1)'(1);
  assign full = count >= full_lvl;
  always_comb begin
    pops = (!read_en1 || empty) ? 2'd0 : (read_en2 && !almost_empty) ? 2'd2 : 2'd1;
    pushes = (full || !write_en1) ? 2'd0 : write_en2 ? 2'd2 : 2'd1;
    read_inst1 = empty ? '0 : inst_mem[head];
    read_pc1 = empty ? '0 : pc_mem[head];
    read_inst2 = (count < (AW+1)'(2)) ? '0 : inst_mem[head1];
    read_pc2 = (count < (AW+1)'(2)) ? '0 : pc_mem[head1];
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + AW'(pops);
      tail <= tail + AW'(pushes);
      count <= count - (AW+1)'(pops) + (AW+1)'(pushes);
    end
  end
  // storage is never cleared: invalid slots are masked to zero on the read side
  always_ff @(posedge clk) begin
    if (!rst && !flush && pushes != 2'd0) begin
      inst_mem[tail] <= write_inst1;
      pc_mem[tail] <= write_pc1;
      if (pushes == 2'd2) begin
        inst_mem[tail1] <= write_inst2;
        pc_mem[tail1] <= write_pc2;
      end
    end
  end
endmodule

// File: doc/inst_fifo.md
Name: inst_fifo

Overview:
- Show-ahead instruction queue between the fetch stage and the dual-issue decode/issue stage.
- Accepts up to two fetched instructions per cycle and presents the two oldest entries to the master and slave decode slots.
- Retires 0, 1 or 2 entries per cycle, according to what issue actually dispatched.
- Drives the empty/almost-empty flags consumed by slave-issue control and the full flag consumed by fetch.

Parameters:
- DEPTH, 16, number of entries; power of two, minimum 4.
- DW, 32, instruction word width; the PC field is also DW bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discard all entries (exception, taken-branch redirect).
- write_en1  input  1  push slot 1 (older instruction).
- write_en2  input  1  push slot 2 (younger instruction); honoured only together with write_en1.
- write_inst1  input  DW  instruction for slot 1.
- write_inst2  input  DW  instruction for slot 2.
- write_pc1  input  DW  PC for slot 1.
- write_pc2  input  DW  PC for slot 2.
- read_en1  input  1  master issued the head entry this cycle.
- read_en2  input  1  slave issued head+1 this cycle; honoured only with read_en1.
- read_inst1  output  DW  instruction at head.
- read_pc1  output  DW  PC at head.
- read_inst2  output  DW  instruction at head+1.
- read_pc2  output  DW  PC at head+1.
- empty  output  1  count == 0.
- almost_empty  output  1  count == 1.
- full  output  1  count >= DEPTH-1; fetch must not push.

Behaviour:
- Storage: circular buffer; head and tail pointers of log2(DEPTH) bits wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- Flags are combinational from the registered count. Read outputs are combinational from storage at head and head+1 (mod DEPTH).
- An output whose entry is invalid (head when count == 0, head+1 when count < 2) drives zero, never stale data.
- Pop amount, from registered count:
  - 0 if !read_en1 or count == 0.
  - 1 if read_en1 && (!read_en2 || count == 1).
  - 2 if read_en1 && read_en2 && count >= 2.
- Push amount: 0 if full or !write_en1; otherwise 1 + write_en2.
- An ignored push or pop has no side effect.
- Because full asserts at DEPTH-1, an accepted push of 2 never overflows, even with zero pops: max count is DEPTH.
- Same-cycle push and pop are both applied:
  - head += pops; tail += pushes; count = count - pops + pushes.
  - A pop never returns data pushed in the same cycle (zero-cycle bypass is not provided).
- Write ordering: slot 1 is written at tail, slot 2 at tail+1 (mod DEPTH). Across the wrap boundary, slot 2 lands at index 0.
- Latency: an entry pushed in cycle N is visible on read_* in cycle N+1.
- flush:
  - Head, tail and count go to 0 at the next edge.
  - Flush has priority over same-cycle push and pop; instructions presented with the flush are dropped.
  - Storage contents need not be cleared, because the zero-output rule hides them.
- Reset:
  - head = tail = count = 0.
  - Outputs after reset: empty=1, almost_empty=0, full=0, all read_* = 0.
  - rst has priority over flush and all traffic.
  - Reset mid-operation discards every entry.
- Only flop storage is used; no RAM macro inference is required.

Test Plan:
1. Reset, then push (write_en1=1, write_en2=1, pc 0x100/0x104) -> next cycle empty=0, almost_empty=0, read_pc1=0x100, read_pc2=0x104.
2. Single entry (pc 0x200); read_en1=1, read_en2=1 -> only 1 popped; read_pc2 was 0 while count==1; next cycle empty=1.
3. Fill with 8 dual pushes (count 16, DEPTH=16) -> full=1 once count reaches 15; a further push with write_en1=1 is ignored and count stays 16; entries pop back in order pc 0x0..0x3C.
4. Wraparound: tail at index 15, dual push pc 0x400/0x404 -> 0x404 stored at index 0; popping yields 0x400 then 0x404.
5. count=5, same cycle push 2 and pop 2 -> count stays 5; head advances by 2; read_pc1 equals the old third entry.
6. count=6, flush=1 together with write_en1=1 and read_en1=1 -> next cycle count=0, empty=1, read_* = 0; rst=1 mid-stream gives the same result.
